// File: rtl/rr_arbiter.sv
// N-way round-robin / fixed-priority arbiter with registered one-hot grant and optional burst hold.
// Latency: 1 cycle req->gnt; backpressure: a grant is held until ack (re-arbitrate, no bubble) or abandon.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IW    = 2,
  parameter int FIXED = 0,
  parameter int BURST = 1,
  parameter int BW    = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          ack,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [BW-1:0] bcnt;
  logic [BW-1:0] bcnt_nxt;
  logic [IW-1:0] base;
  logic [IW-1:0] cand;
  logic [IW-1:0] win_idx;
  logic          win_vld;
  logic          keep;

  // On an ack the just-served index becomes the new pointer, so search from gnt_idx directly.
  always_comb begin
    base    = (state == GRANT) ? gnt_idx : ptr;
    cand    = '0;
    win_vld = 1'b0;
    win_idx = '0;
    if (FIXED != 0) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          win_vld = 1'b1;
          win_idx = IW'(i);
        end
      end
    end else begin
      // Walk the ring from farthest to nearest so the nearest set request wins.
      for (int k = N; k >= 1; k--) begin
        cand = IW'((int'(base) + k) % N);
        if (req[cand]) begin
          win_vld = 1'b1;
          win_idx = cand;
        end
      end
    end
  end

  // A sole requester re-winning past its allowance saturates the count, so any newcomer rotates in next.
  always_comb begin
    keep     = (BURST > 1) && (FIXED == 0) && req[gnt_idx] && (int'(bcnt) + 1 < BURST);
    bcnt_nxt = (int'(bcnt) + 1 < BURST) ? bcnt + 1'b1 : BW'(BURST - 1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      ptr       <= IW'(N - 1);
      bcnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state     <= GRANT;
            gnt       <= N'(1) << win_idx;
            gnt_idx   <= win_idx;
            gnt_valid <= 1'b1;
            bcnt      <= '0;
          end
        end
        GRANT: begin
          if (ack) begin
            ptr <= gnt_idx;
            if (keep) begin
              bcnt <= bcnt_nxt;
            end else if (win_vld) begin
              gnt     <= N'(1) << win_idx;
              gnt_idx <= win_idx;
              bcnt    <= (win_idx == gnt_idx) ? bcnt_nxt : '0;
            end else begin
              state     <= IDLE;
              gnt       <= '0;
              gnt_idx   <= '0;
              gnt_valid <= 1'b0;
            end
          end else if (!req[gnt_idx]) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: three instances (round-robin, burst=2, fixed priority) under directed and random traffic.
module tb_rr_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_n;
  logic [2:0][N-1:0]    req_a;
  logic [2:0]           ack_a;
  logic [N-1:0]         gnt0, gnt1, gnt2;
  logic [1:0]           idx0, idx1, idx2;
  logic                 vld0, vld1, vld2;
  logic [2:0][N-1:0]    gnt_a;
  logic [2:0][1:0]      idx_a;
  logic [2:0]           vld_a;

  assign gnt_a = {gnt2, gnt1, gnt0};
  assign idx_a = {idx2, idx1, idx0};
  assign vld_a = {vld2, vld1, vld0};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state per instance: granted?, granted index, last acked index, acks within current burst.
  int m_vld[3];
  int m_idx[3];
  int m_ptr[3];
  int m_cnt[3];

  rr_arbiter #(.N(4), .IW(2), .FIXED(0), .BURST(1), .BW(2)) u_rr (
    .clk(clk), .reset_n(reset_n), .req(req_a[0]), .ack(ack_a[0]),
    .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(vld0));
  rr_arbiter #(.N(4), .IW(2), .FIXED(0), .BURST(2), .BW(2)) u_bu (
    .clk(clk), .reset_n(reset_n), .req(req_a[1]), .ack(ack_a[1]),
    .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(vld1));
  rr_arbiter #(.N(4), .IW(2), .FIXED(1), .BURST(1), .BW(2)) u_fx (
    .clk(clk), .reset_n(reset_n), .req(req_a[2]), .ack(ack_a[2]),
    .gnt(gnt2), .gnt_idx(idx2), .gnt_valid(vld2));

  function automatic int pick(logic [N-1:0] r, int base, bit fixed);
    if (fixed) begin
      for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
      return -1;
    end
    for (int k = 1; k <= N; k++) if (r[(base + k) % N]) return (base + k) % N;
    return -1;
  endfunction

  function automatic void model_step(int d, logic [N-1:0] r, logic a);
    int burst;
    bit fixed;
    int w;
    burst = (d == 1) ? 2 : 1;
    fixed = (d == 2);
    if (m_vld[d] == 0) begin
      w = pick(r, m_ptr[d], fixed);
      if (w >= 0) begin
        m_vld[d] = 1; m_idx[d] = w; m_cnt[d] = 0;
      end
    end else if (a) begin
      m_ptr[d] = m_idx[d];
      if (!fixed && r[m_idx[d]] && m_cnt[d] + 1 < burst) w = m_idx[d];
      else w = pick(r, m_idx[d], fixed);
      if (w < 0) m_vld[d] = 0;
      else begin
        if (w == m_idx[d]) m_cnt[d] = (m_cnt[d] + 1 < burst) ? m_cnt[d] + 1 : burst - 1;
        else m_cnt[d] = 0;
        m_idx[d] = w;
      end
    end else if (!r[m_idx[d]]) begin
      m_vld[d] = 0;
    end
  endfunction

  // Pulse reset for one full cycle; returns at the releasing falling edge.
  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req_a   = '0;
    ack_a   = '0;
    for (int d = 0; d < 3; d++) begin
      m_vld[d] = 0; m_idx[d] = 0; m_ptr[d] = N - 1; m_cnt[d] = 0;
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    req_a    = '0;
    ack_a    = '0;
    req_a[0] = 4'b1111;
    #12;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (gnt_a[d] !== 4'b0000 || idx_a[d] !== 2'd0 || vld_a[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: got gnt=%b idx=%0d vld=%b want 0/0/0", d, gnt_a[d], idx_a[d], vld_a[d]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (gnt_a[0] !== 4'b0001 || idx_a[0] !== 2'd0 || vld_a[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL first_grant: got gnt=%b idx=%0d vld=%b want 0001/0/1", gnt_a[0], idx_a[0], vld_a[0]);
    end
  endtask

  // Continues from test_reset: idx0 is granted with req=1111.
  task automatic test_rotation();
    int exp_seq[4] = '{1, 2, 3, 0};
    ack_a[0] = 1'b1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      n_checks++;
      if (idx_a[0] !== 2'(exp_seq[s]) || vld_a[0] !== 1'b1 || gnt_a[0] !== (4'b0001 << exp_seq[s])) begin
        n_fail++;
        $display("FAIL rotation step%0d: got idx=%0d vld=%b gnt=%b want idx=%0d vld=1", s, idx_a[0], vld_a[0], gnt_a[0], exp_seq[s]);
      end
    end
    ack_a[0] = 1'b0;
  endtask

  task automatic test_wrap_skip();
    apply_reset();
    req_a[0] = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (idx_a[0] !== 2'd2 || vld_a[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_setup: got idx=%0d vld=%b want 2/1", idx_a[0], vld_a[0]);
    end
    ack_a[0] = 1'b1;
    req_a[0] = 4'b0011;
    @(negedge clk);
    n_checks++;
    if (idx_a[0] !== 2'd0 || vld_a[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_idx0: got idx=%0d vld=%b want 0/1", idx_a[0], vld_a[0]);
    end
    @(negedge clk);
    n_checks++;
    if (idx_a[0] !== 2'd1 || gnt_a[0] !== 4'b0010) begin
      n_fail++;
      $display("FAIL wrap_idx1: got idx=%0d gnt=%b want 1/0010", idx_a[0], gnt_a[0]);
    end
    ack_a[0] = 1'b0;
    req_a[0] = 4'b0000;
  endtask

  task automatic test_abandon();
    apply_reset();
    req_a[0] = 4'b0001;
    @(negedge clk);
    ack_a[0] = 1'b1;
    req_a[0] = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (idx_a[0] !== 2'd1 || vld_a[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL abandon_setup: got idx=%0d vld=%b want 1/1", idx_a[0], vld_a[0]);
    end
    ack_a[0] = 1'b0;
    req_a[0] = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (vld_a[0] !== 1'b0 || gnt_a[0] !== 4'b0000) begin
      n_fail++;
      $display("FAIL abandon_clear: got vld=%b gnt=%b want 0/0000", vld_a[0], gnt_a[0]);
    end
    req_a[0] = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (idx_a[0] !== 2'd2 || vld_a[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL abandon_regrant: got idx=%0d vld=%b want 2/1", idx_a[0], vld_a[0]);
    end
    req_a[0] = 4'b0000;
    @(negedge clk);
    // Pointer must still be 0 (no ack since idx0): with req 0110 the search from 1 picks 1.
    req_a[0] = 4'b0110;
    @(negedge clk);
    n_checks++;
    if (idx_a[0] !== 2'd1 || vld_a[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL abandon_ptr_kept: got idx=%0d vld=%b want 1/1", idx_a[0], vld_a[0]);
    end
    req_a[0] = 4'b0000;
  endtask

  task automatic test_burst();
    int exp_seq[5] = '{0, 0, 1, 1, 0};
    apply_reset();
    req_a[1] = 4'b0011;
    ack_a[1] = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      n_checks++;
      if (idx_a[1] !== 2'(exp_seq[s]) || vld_a[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL burst step%0d: got idx=%0d vld=%b want idx=%0d vld=1", s, idx_a[1], vld_a[1], exp_seq[s]);
      end
    end
    ack_a[1] = 1'b0;
    req_a[1] = 4'b0000;
  endtask

  task automatic test_fixed_and_reset();
    apply_reset();
    req_a[2] = 4'b0111;
    req_a[0] = 4'b1111;
    @(negedge clk);
    n_checks++;
    if (idx_a[2] !== 2'd2 || gnt_a[2] !== 4'b0100) begin
      n_fail++;
      $display("FAIL fixed_first: got idx=%0d gnt=%b want 2/0100", idx_a[2], gnt_a[2]);
    end
    ack_a[2] = 1'b1;
    @(negedge clk);
    ack_a[2] = 1'b0;
    n_checks++;
    if (idx_a[2] !== 2'd2 || vld_a[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL fixed_after_ack: got idx=%0d vld=%b want 2/1", idx_a[2], vld_a[2]);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (vld_a !== 3'b000 || gnt_a !== '0 || idx_a !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got vld=%b gnt=%h idx=%h want all zero", vld_a, gnt_a, idx_a);
    end
  endtask

  task automatic test_random(input int d, input int cycles);
    logic [N-1:0] r;
    logic         a;
    logic [N-1:0] eg;
    logic [1:0]   ei;
    apply_reset();
    r = '0;
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      a = 1'($urandom_range(0, 1));
      req_a[d] = r;
      ack_a[d] = a;
      model_step(d, r, a);
      @(negedge clk);
      eg = (m_vld[d] != 0) ? (4'b0001 << m_idx[d]) : 4'b0000;
      ei = (m_vld[d] != 0) ? 2'(m_idx[d]) : 2'd0;
      n_checks++;
      if (vld_a[d] !== 1'(m_vld[d]) || gnt_a[d] !== eg || idx_a[d] !== ei) begin
        n_fail++;
        $display("FAIL random dut%0d cycle%0d: got vld=%b gnt=%b idx=%0d want vld=%0d gnt=%b idx=%0d",
                 d, c, vld_a[d], gnt_a[d], idx_a[d], m_vld[d], eg, ei);
      end
      n_checks++;
      if (!$onehot0(gnt_a[d]) || gnt_a[d] !== (vld_a[d] ? (4'b0001 << idx_a[d]) : 4'b0000)) begin
        n_fail++;
        $display("FAIL invariant dut%0d cycle%0d: gnt=%b idx=%0d vld=%b not consistent one-hot", d, c, gnt_a[d], idx_a[d], vld_a[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_wrap_skip();
    test_abandon();
    test_burst();
    test_fixed_and_reset();
    test_random(0, 400);
    test_random(1, 400);
    test_random(2, 400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
Parametrised N-way arbiter with a registered grant. It is the sequential successor to the combinational priority encoders. Supported modes are round-robin (rotating pointer) and fixed-priority. An optional burst allowance lets a winner keep the grant for several consecutive transfers. It sits in front of shared resources (memory port, multi-cycle MDU, bus) and resolves requests from several pipeline clients over a grant/ack handshake.

Parameters:
N, 4, number of requesters (N >= 2)
IW, 2, width of encoded index; IW = ceil(log2(N))
FIXED, 0, 1 = fixed priority (highest index wins, pointer ignored); 0 = round-robin
BURST, 1, max consecutive acked grants to the same requester before forced rotation (>= 1)
BW, 2, width of burst counter; must hold BURST-1

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
req  in  N  request vector; req[i] held high until served or abandoned
ack  in  1  consumer accepted the current grant this cycle (valid only while gnt_valid=1)
gnt  out  N  one-hot registered grant; all zero when gnt_valid=0
gnt_idx  out  IW  binary index of the granted requester; 0 when gnt_valid=0
gnt_valid  out  1  a grant is active

Behaviour:
- Reset (async, reset_n=0): gnt=0, gnt_idx=0, gnt_valid=0, state=IDLE, ptr=N-1, burst count=0. This takes effect immediately, mid-grant included; no transaction completes.
- ptr holds the last acked index. The round-robin search order is ptr+1, ptr+2, ... mod N, and the first set req bit wins.
- With FIXED=1, the highest set req index wins (x3 > x2 > x1 convention).
- States: IDLE, GRANT. All outputs are registered, with one cycle of latency from req to gnt.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise, the winner is registered into gnt/gnt_idx, gnt_valid=1, and the state goes to GRANT.
- GRANT: gnt is held stable until one of the following events.
  - ack=1:
    - ptr <= gnt_idx.
    - Burst count increments. It resets to 0 on any change of granted index.
    - If BURST>1, FIXED=0, req[gnt_idx] is still high, and count+1 < BURST: keep the same grant next cycle.
    - Otherwise, arbitrate the current req with the updated ptr and register the winner, back-to-back with no bubble.
    - If no req remains: go to IDLE and gnt_valid=0.
  - ack=0 and req[gnt_idx]=0 (abandon): gnt cleared and gnt_valid=0 next cycle; state goes to IDLE. ptr and the burst count are unchanged.
  - ack=1 while req[gnt_idx]=0 in the same cycle: treated as ack (ack wins).
  - Otherwise: hold.
- Requests arriving while a grant is held are never preempted. They are evaluated only at the ack/abandon edge.
- Wrap-around: if ptr=N-1, the search starts at 0. If ptr is the only requester, it wins again (BURST limit is then bypassed, since no other requester exists).
- gnt is always one-hot or zero, and gnt_idx always matches gnt. These must hold as bench assertions every cycle.
- ack while gnt_valid=0 is ignored.

Test Plan:
- Reset/first grant (N=4, FIXED=0, BURST=1):
  - While reset_n=0, all outputs are 0.
  - Release reset with req=4'b1111. At the first edge: gnt=4'b0001, gnt_idx=0, gnt_valid=1.
- Rotation: req=4'b1111, ack=1 every cycle -> gnt_idx sequence 0,1,2,3,0, with gnt_valid continuously 1.
- Wrap skip: after idx2 is acked (ptr=2), req=4'b0011 -> next grant idx0, then idx1 after ack.
- Abandon:
  - Granted idx1 with ptr=0; drop req[1] without ack. Next cycle: gnt_valid=0, gnt=0.
  - Then req=4'b0100 -> idx2 one cycle later, and ptr is still 0 before that ack.
- Burst (BURST=2): req=4'b0011, ack every cycle -> gnt_idx 0,0,1,1,0.
- Fixed mode and reset mid-operation:
  - FIXED=1, req=4'b0111 -> gnt_idx=2; after ack with req unchanged -> idx2 again.
  - Assert reset_n=0 mid-grant -> gnt=0 and gnt_valid=0 within the same cycle, with no clock edge needed.
